// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding UART_duplex: queues bus writes and launches one byte per UART frame,
// handshaking on uart_busy rise/fall with a bounded wait for the rise.
module uart_tx_queue #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     uart_busy,
    output logic                     tx_send,
    output logic [7:0]               tx_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned LevelW = AddrW + 1;
    localparam int unsigned TimerW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [LevelW-1:0] FullLevel = LevelW'(DEPTH);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(START_TIMEOUT - 1);

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StLaunch    = 2'd1;
    localparam logic [1:0] StWaitStart = 2'd2;
    localparam logic [1:0] StWaitDone  = 2'd3;

    logic [7:0]        mem_q [DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [1:0]        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;

    logic push;
    logic pop;
    logic ovf_set;

    assign full  = (level_q == FullLevel);
    assign empty = (level_q == '0);
    assign level = level_q;

    // full is the registered value, so a push on a pop edge is still refused when full.
    assign push    = wr_en & ~full & ~flush;
    assign ovf_set = wr_en & full & ~flush;
    assign pop     = (state_q == StIdle) & ~empty & ~uart_busy & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        tx_data_d = tx_data_q;
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (uart_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TimerLast) begin
                    // UART never acknowledged; the byte is dropped.
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!uart_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_send = (state_q == StLaunch);
    assign tx_data = tx_data_q;
    assign overflow = overflow_q;

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            state_q    <= StIdle;
            timer_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected bytes, a monitor checks each
// tx_send launch against the queue, and a simple UART model drives uart_busy.
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       uart_busy;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       overflow_clr;

    logic busy_model;
    logic busy_hold;
    bit   model_en;
    int   busy_len;

    logic [7:0] exp_q[$];
    int         n_cmp;
    int         n_err;
    int         n_sends;
    int         cyc;
    int         send_cyc[$];

    assign uart_busy = busy_model | busy_hold;

    uart_tx_queue #(
        .DEPTH        (16),
        .START_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .uart_busy   (uart_busy),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    initial forever #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART model: busy rises the negedge after a launch and stays up for busy_len clocks.
    initial begin
        busy_model = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && tx_send && !rst) begin
                busy_model = 1'b1;
                repeat (busy_len) @(negedge clk);
                busy_model = 1'b0;
            end
        end
    end

    // Monitor: every launch must match the head of the scoreboard.
    initial begin
        logic       prev_send;
        logic [7:0] e;
        int         last_cyc;
        prev_send = 1'b0;
        last_cyc  = -100;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && tx_send) begin
                chk("no_back_to_back_send", {31'd0, prev_send}, 0);
                chk("send_while_busy", {31'd0, uart_busy}, 0);
                chk("send_spacing_ge4", (cyc - last_cyc >= 4) ? 1 : 0, 1);
                chk("send_expected", exp_q.size() > 0 ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tx_data_order", {24'd0, tx_data}, {24'd0, e});
                end
                last_cyc = cyc;
                send_cyc.push_back(cyc);
                n_sends++;
            end
            prev_send = rst ? 1'b0 : tx_send;
        end
    end

    task automatic push(input logic [7:0] d, input bit accept);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_idle();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_sends(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (n_sends < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk(name, n_sends, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        n_cmp = 0; n_err = 0; n_sends = 0;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        overflow_clr = 1'b0; busy_hold = 1'b0; model_en = 1'b1; busy_len = 10;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_send", {31'd0, tx_send}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 8'h00);
        chk("rst_level", {27'd0, level}, 0);
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single byte, one-clock launch latency
        push(8'h41, 1);
        chk("t1_level_after_push", {27'd0, level}, 1);
        chk("t1_no_send_yet", {31'd0, tx_send}, 0);
        wr_idle();
        @(posedge clk);
        #1;
        chk("t1_send_next_clk", {31'd0, tx_send}, 1);
        chk("t1_tx_data", {24'd0, tx_data}, 8'h41);
        chk("t1_level_zero", {27'd0, level}, 0);
        wait_sends(1, 50, "t1_sends");
        repeat (20) @(posedge clk);

        // 2: three back-to-back pushes, busy 10 clks per frame
        push(8'h41, 1);
        push(8'h42, 1);
        push(8'h43, 1);
        wr_idle();
        wait_sends(4, 200, "t2_sends");
        repeat (20) @(posedge clk);

        // 3: fill with busy held, overflow on 17th push, then clear
        @(negedge clk);
        busy_hold = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1);
        chk("t3_level16", {27'd0, level}, 16);
        chk("t3_full", {31'd0, full}, 1);
        chk("t3_no_overflow_yet", {31'd0, overflow}, 0);
        push(8'hFF, 0);
        chk("t3_overflow_set", {31'd0, overflow}, 1);
        chk("t3_level_still16", {27'd0, level}, 16);
        @(negedge clk);
        wr_en = 1'b0;
        overflow_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_overflow_cleared", {31'd0, overflow}, 0);
        @(negedge clk);
        overflow_clr = 1'b0;

        // 4: full queue, pop and push on the same edge
        @(negedge clk);
        busy_hold = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'hEE;
        @(posedge clk);
        #1;
        chk("t4_pop_happened", {31'd0, tx_send}, 1);
        chk("t4_level15", {27'd0, level}, 15);
        chk("t4_overflow", {31'd0, overflow}, 1);
        chk("t4_not_full", {31'd0, full}, 0);
        wr_idle();
        wait_sends(20, 600, "t3_t4_drain");
        chk("t4_drained_empty", {31'd0, empty}, 1);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        repeat (20) @(posedge clk);

        // 5: UART never answers; start timeout returns to idle and sends the next byte
        model_en = 1'b0;
        send_cyc.delete();
        push(8'hA1, 1);
        push(8'hA2, 1);
        wr_idle();
        wait_sends(22, 100, "t5_sends");
        chk("t5_two_sends", send_cyc.size(), 2);
        if (send_cyc.size() == 2) chk("t5_timeout_gap", send_cyc[1] - send_cyc[0], 10);
        repeat (15) @(posedge clk);
        model_en = 1'b1;
        chk("t5_scoreboard_empty", exp_q.size(), 0);

        // 7: flush drops queued bytes and a same-edge push without overflow
        @(negedge clk);
        busy_hold = 1'b1;
        push(8'hC1, 1);
        push(8'hC2, 1);
        push(8'hC3, 1);
        @(negedge clk);
        wr_data = 8'hC4;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_level0", {27'd0, level}, 0);
        chk("flush_empty", {31'd0, empty}, 1);
        chk("flush_no_overflow", {31'd0, overflow}, 0);
        exp_q.delete();
        @(negedge clk);
        wr_en = 1'b0; flush = 1'b0; busy_hold = 1'b0;
        base = n_sends;
        repeat (20) @(posedge clk);
        #2;
        chk("flush_no_send", n_sends, base);

        // 6: reset in WAIT_DONE with 5 queued
        for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i), 1);
        wr_idle();
        wait_sends(base + 1, 50, "t6_first_send");
        repeat (3) @(posedge clk);
        #1;
        chk("t6_level5", {27'd0, level}, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_tx_send", {31'd0, tx_send}, 0);
        chk("t6_rst_level", {27'd0, level}, 0);
        chk("t6_rst_empty", {31'd0, empty}, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = n_sends;
        repeat (40) @(posedge clk);
        #2;
        chk("t6_no_stray_send", n_sends, base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
